// File: rtl/mips_ctrl_pkg.sv
// Shared constants for the multicycle MIPS control path: opcodes, ALUOp and
// mux select codes, FSM state encoding and the decoded control word.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] FUNCT_JR = 6'b001000;

  localparam logic [2:0] ALUOP_ADD   = 3'b000;
  localparam logic [2:0] ALUOP_RTYPE = 3'b010;
  localparam logic [2:0] ALUOP_SUB   = 3'b011;
  localparam logic [2:0] ALUOP_AND   = 3'b100;
  localparam logic [2:0] ALUOP_OR    = 3'b101;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_REGA   = 2'b11;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_BRANCH = 2'b11;

  localparam logic [3:0] S_RESET     = 4'd0;
  localparam logic [3:0] S_FETCH     = 4'd1;
  localparam logic [3:0] S_DECODE    = 4'd2;
  localparam logic [3:0] S_MEM_ADDR  = 4'd3;
  localparam logic [3:0] S_MEM_READ  = 4'd4;
  localparam logic [3:0] S_MEM_WRITE = 4'd5;
  localparam logic [3:0] S_MEM_WB    = 4'd6;
  localparam logic [3:0] S_R_EXEC    = 4'd7;
  localparam logic [3:0] S_R_WB      = 4'd8;
  localparam logic [3:0] S_I_EXEC    = 4'd9;
  localparam logic [3:0] S_I_WB      = 4'd10;
  localparam logic [3:0] S_BRANCH    = 4'd11;
  localparam logic [3:0] S_JUMP      = 4'd12;
  localparam logic [3:0] S_JR        = 4'd13;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       ir_write;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       i_or_d;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       ext_sel;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal_op;
  } ctrl_t;

  function automatic logic is_legal_op(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_ANDI, OP_ORI: is_legal_op = 1'b1;
      default: is_legal_op = 1'b0;
    endcase
  endfunction

  function automatic logic is_wait_state(input logic [3:0] s);
    is_wait_state = (s == S_FETCH) || (s == S_MEM_READ) || (s == S_MEM_WRITE);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// Combinational mapping of FSM state (plus opcode for immediate ops and
// mem_ready for the fetch handshake) to the datapath control word.
module multicycle_ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  logic [3:0] state_i,
  input  logic [5:0] opcode_i,
  input  logic       mem_ready_i,
  output ctrl_t      ctrl_o
);

  logic [2:0] imm_alu_op_s;
  logic       imm_ext_s;

  // ALU operation and extension mode for the immediate ALU instructions
  always_comb begin
    imm_alu_op_s = ALUOP_ADD;
    imm_ext_s    = 1'b0;
    case (opcode_i)
      OP_ANDI: begin
        imm_alu_op_s = ALUOP_AND;
        imm_ext_s    = 1'b1;
      end
      OP_ORI: begin
        imm_alu_op_s = ALUOP_OR;
        imm_ext_s    = 1'b1;
      end
      default: begin
        imm_alu_op_s = ALUOP_ADD;
        imm_ext_s    = 1'b0;
      end
    endcase
  end

  // Per-state control word; anything not listed stays 0
  always_comb begin
    ctrl_o = '0;
    case (state_i)
      S_FETCH: begin
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.alu_src_b = SRCB_FOUR;
        ctrl_o.alu_op    = ALUOP_ADD;
        ctrl_o.pc_source = PCSRC_ALU;
        ctrl_o.ir_write  = mem_ready_i;
        ctrl_o.pc_write  = mem_ready_i;
      end
      S_DECODE: begin
        ctrl_o.alu_src_b  = SRCB_BRANCH;
        ctrl_o.alu_op     = ALUOP_ADD;
        ctrl_o.illegal_op = ~is_legal_op(opcode_i);
      end
      S_MEM_ADDR: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = ALUOP_ADD;
      end
      S_MEM_READ: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.i_or_d   = 1'b1;
      end
      S_MEM_WRITE: begin
        ctrl_o.mem_write = 1'b1;
        ctrl_o.i_or_d    = 1'b1;
      end
      S_MEM_WB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
      end
      S_R_EXEC: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_op    = ALUOP_RTYPE;
      end
      S_R_WB: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.reg_dst   = 1'b1;
      end
      S_I_EXEC: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = imm_alu_op_s;
        ctrl_o.ext_sel   = imm_ext_s;
      end
      // ALU op and extension are held so ALUOut stays valid during write-back
      S_I_WB: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.alu_op    = imm_alu_op_s;
        ctrl_o.ext_sel   = imm_ext_s;
      end
      S_BRANCH: begin
        ctrl_o.alu_src_a     = 1'b1;
        ctrl_o.alu_op        = ALUOP_SUB;
        ctrl_o.pc_write_cond = 1'b1;
        ctrl_o.pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        ctrl_o.pc_write  = 1'b1;
        ctrl_o.pc_source = PCSRC_JUMP;
      end
      S_JR: begin
        ctrl_o.pc_write  = 1'b1;
        ctrl_o.pc_source = PCSRC_REGA;
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle MIPS datapath: instruction sequencing,
// memory wait counter with timeout pulse, and control-word outputs.
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int WAIT_LIMIT = 255
)
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       ir_write,
  output logic       reg_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       i_or_d,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       ext_sel,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic [1:0] pc_source,
  output logic       illegal_op,
  output logic       mem_timeout,
  output logic [3:0] state
);

  localparam logic [7:0] WAIT_LIM_C = 8'(WAIT_LIMIT);

  logic [3:0] state_q, state_d;
  logic [7:0] wait_q, wait_d;
  logic       is_load_q, is_load_d;
  logic       in_wait_s;
  logic       unused_s;
  ctrl_t      ctrl_s;

  // zero only qualifies pc_write_cond inside the datapath
  assign unused_s  = zero;
  assign in_wait_s = is_wait_state(state_q);

  // Next-state sequencing
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RESET: state_d = S_FETCH;
      S_FETCH: begin
        if (mem_ready) state_d = S_DECODE;
        else           state_d = S_FETCH;
      end
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_RTYPE: begin
            if (funct == FUNCT_JR) state_d = S_JR;
            else                   state_d = S_R_EXEC;
          end
          OP_ADDI, OP_ANDI, OP_ORI: state_d = S_I_EXEC;
          OP_BEQ:  state_d = S_BRANCH;
          OP_J:    state_d = S_JUMP;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEM_ADDR: begin
        if (is_load_q) state_d = S_MEM_READ;
        else           state_d = S_MEM_WRITE;
      end
      S_MEM_READ: begin
        if (mem_ready) state_d = S_MEM_WB;
        else           state_d = S_MEM_READ;
      end
      S_MEM_WRITE: begin
        if (mem_ready) state_d = S_FETCH;
        else           state_d = S_MEM_WRITE;
      end
      S_R_EXEC: state_d = S_R_WB;
      S_I_EXEC: state_d = S_I_WB;
      S_MEM_WB, S_R_WB, S_I_WB, S_BRANCH, S_JUMP, S_JR: state_d = S_FETCH;
      default: state_d = S_FETCH;
    endcase
  end

  // lw/sw choice is captured in DECODE so MEM_ADDR does not look at the IR
  always_comb begin
    if (state_q == S_DECODE) is_load_d = (opcode == OP_LW);
    else                     is_load_d = is_load_q;
  end

  // Stall counter: every path into a wait state passes through a clear,
  // so it starts at 0 on entry; it saturates at the limit.
  always_comb begin
    if (!in_wait_s || mem_ready) wait_d = 8'd0;
    else if (wait_q != WAIT_LIM_C) wait_d = wait_q + 8'd1;
    else wait_d = wait_q;
  end

  // State and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_RESET;
      wait_q    <= 8'd0;
      is_load_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      is_load_q <= is_load_d;
    end
  end

  multicycle_ctrl_decode u_decode (
    .state_i     (state_q),
    .opcode_i    (opcode),
    .mem_ready_i (mem_ready),
    .ctrl_o      (ctrl_s)
  );

  assign pc_write      = ctrl_s.pc_write;
  assign pc_write_cond = ctrl_s.pc_write_cond;
  assign ir_write      = ctrl_s.ir_write;
  assign reg_write     = ctrl_s.reg_write;
  assign mem_read      = ctrl_s.mem_read;
  assign mem_write     = ctrl_s.mem_write;
  assign i_or_d        = ctrl_s.i_or_d;
  assign mem_to_reg    = ctrl_s.mem_to_reg;
  assign reg_dst       = ctrl_s.reg_dst;
  assign ext_sel       = ctrl_s.ext_sel;
  assign alu_src_a     = ctrl_s.alu_src_a;
  assign alu_src_b     = ctrl_s.alu_src_b;
  assign alu_op        = ctrl_s.alu_op;
  assign pc_source     = ctrl_s.pc_source;
  assign illegal_op    = ctrl_s.illegal_op;
  // Fires during the stall cycle that takes the counter up to the limit
  assign mem_timeout   = in_wait_s && !mem_ready && (wait_q == WAIT_LIM_C - 8'd1);
  assign state         = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed table, reset-abort
// sequence and randomized instruction stream against an instruction-level model.
`timescale 1ns/1ps
module tb_multicycle_control;
  import mips_ctrl_pkg::*;

  localparam int WAIT_LIMIT = 255;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic [5:0] funct = 6'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       pc_write, pc_write_cond, ir_write, reg_write, mem_read, mem_write;
  logic       i_or_d, mem_to_reg, reg_dst, ext_sel, alu_src_a, illegal_op, mem_timeout;
  logic [1:0] alu_src_b, pc_source;
  logic [2:0] alu_op;
  logic [3:0] state;

  multicycle_control #(.WAIT_LIMIT(WAIT_LIMIT)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .ir_write(ir_write), .reg_write(reg_write), .mem_read(mem_read),
    .mem_write(mem_write), .i_or_d(i_or_d), .mem_to_reg(mem_to_reg),
    .reg_dst(reg_dst), .ext_sel(ext_sel), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_source(pc_source),
    .illegal_op(illegal_op), .mem_timeout(mem_timeout), .state(state)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  logic [23:0] obs_s;
  assign obs_s = {state, pc_write, pc_write_cond, ir_write, reg_write, mem_read,
                  mem_write, i_or_d, mem_to_reg, reg_dst, ext_sel, alu_src_a,
                  alu_src_b, alu_op, pc_source, illegal_op, mem_timeout};

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    int         fw;
    int         mw;
    int         cyc;
    logic [3:0] last;
    int         tmo;
    int         ill;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [5:0] op, input logic [5:0] fn, input int fw,
                              input int mw, input int cyc, input logic [3:0] last,
                              input int tmo, input int ill);
    vec_t v;
    v.op = op; v.fn = fn; v.fw = fw; v.mw = mw;
    v.cyc = cyc; v.last = last; v.tmo = tmo; v.ill = ill;
    return v;
  endfunction

  function automatic logic legal(input logic [5:0] op);
    return op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100,
                      6'b000010, 6'b001000, 6'b001100, 6'b001101};
  endfunction

  // Expected outputs for one cycle, straight from the per-state table
  function automatic logic [23:0] exp_word(input logic [3:0] st, input logic [5:0] op,
                                           input logic mr, input int stall);
    logic pw, pwc, irw, rw, mrd, mwr, iod, m2r, rd, ext, asa, ill, tmo, i_ext;
    logic [1:0] asb, pcs;
    logic [2:0] aop, i_aop;
    {pw, pwc, irw, rw, mrd, mwr, iod, m2r, rd, ext, asa, ill, tmo} = '0;
    asb = 2'b00; pcs = 2'b00; aop = 3'b000;
    i_aop = (op == 6'b001100) ? 3'b100 : (op == 6'b001101) ? 3'b101 : 3'b000;
    i_ext = (op == 6'b001100) || (op == 6'b001101);
    case (st)
      S_FETCH:     begin mrd = 1'b1; asb = 2'b01; pw = mr; irw = mr; end
      S_DECODE:    begin asb = 2'b11; ill = !legal(op); end
      S_MEM_ADDR:  begin asa = 1'b1; asb = 2'b10; end
      S_MEM_READ:  begin mrd = 1'b1; iod = 1'b1; end
      S_MEM_WRITE: begin mwr = 1'b1; iod = 1'b1; end
      S_MEM_WB:    begin rw = 1'b1; m2r = 1'b1; end
      S_R_EXEC:    begin asa = 1'b1; aop = 3'b010; end
      S_R_WB:      begin rw = 1'b1; rd = 1'b1; end
      S_I_EXEC:    begin asa = 1'b1; asb = 2'b10; aop = i_aop; ext = i_ext; end
      S_I_WB:      begin rw = 1'b1; aop = i_aop; ext = i_ext; end
      S_BRANCH:    begin asa = 1'b1; aop = 3'b011; pwc = 1'b1; pcs = 2'b01; end
      S_JUMP:      begin pw = 1'b1; pcs = 2'b10; end
      S_JR:        begin pw = 1'b1; pcs = 2'b11; end
      default:     begin end
    endcase
    tmo = (stall == WAIT_LIMIT);
    return {st, pw, pwc, irw, rw, mrd, mwr, iod, m2r, rd, ext, asa, asb, aop, pcs, ill, tmo};
  endfunction

  // Runs one instruction starting in FETCH; the model is a list of phases
  // with stall counts, checked every cycle.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int fw,
                           input int mw, input bit rnd, output int ncyc,
                           output logic [3:0] last_st, output int n_tmo, output int n_ill);
    logic [3:0] plan[$];
    int         waits[$];
    logic       mr;
    int         stall;
    plan = {S_FETCH, S_DECODE};
    waits = {fw, 0};
    if (op == 6'b100011) begin
      plan.push_back(S_MEM_ADDR); waits.push_back(0);
      plan.push_back(S_MEM_READ); waits.push_back(mw);
      plan.push_back(S_MEM_WB);   waits.push_back(0);
    end else if (op == 6'b101011) begin
      plan.push_back(S_MEM_ADDR);  waits.push_back(0);
      plan.push_back(S_MEM_WRITE); waits.push_back(mw);
    end else if (op == 6'b000000 && fn == 6'b001000) begin
      plan.push_back(S_JR); waits.push_back(0);
    end else if (op == 6'b000000) begin
      plan.push_back(S_R_EXEC); waits.push_back(0);
      plan.push_back(S_R_WB);   waits.push_back(0);
    end else if (op inside {6'b001000, 6'b001100, 6'b001101}) begin
      plan.push_back(S_I_EXEC); waits.push_back(0);
      plan.push_back(S_I_WB);   waits.push_back(0);
    end else if (op == 6'b000100) begin
      plan.push_back(S_BRANCH); waits.push_back(0);
    end else if (op == 6'b000010) begin
      plan.push_back(S_JUMP); waits.push_back(0);
    end
    ncyc = 0; n_tmo = 0; n_ill = 0; last_st = 4'd0;
    opcode = op; funct = fn;
    foreach (plan[p]) begin
      for (int k = 0; k <= waits[p]; k++) begin
        if (plan[p] inside {S_FETCH, S_MEM_READ, S_MEM_WRITE}) begin
          mr = (k == waits[p]);
          stall = mr ? 0 : k + 1;
        end else begin
          mr = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
          stall = 0;
        end
        mem_ready = mr;
        zero = 1'($urandom_range(0, 1));
        @(negedge clk);
        check($sformatf("cycle op=%b st=%0d k=%0d", op, plan[p], k), 32'(obs_s),
              32'(exp_word(plan[p], op, mr, stall)));
        n_tmo += int'(mem_timeout);
        n_ill += int'(illegal_op);
        last_st = state;
        ncyc++;
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ncyc, n_tmo, n_ill, base;
    logic [3:0] last;
    logic [5:0] op, fn;
    int fw, mw;

    tbl.push_back(mk(6'b100011, 6'b000000, 0, 0, 5, S_MEM_WB, 0, 0));
    tbl.push_back(mk(6'b000000, 6'b100000, 0, 0, 4, S_R_WB, 0, 0));
    tbl.push_back(mk(6'b000000, 6'b001000, 0, 0, 3, S_JR, 0, 0));
    tbl.push_back(mk(6'b000100, 6'b000000, 0, 0, 3, S_BRANCH, 0, 0));
    tbl.push_back(mk(6'b000100, 6'b000000, 0, 0, 3, S_BRANCH, 0, 0));
    tbl.push_back(mk(6'b000010, 6'b000000, 0, 0, 3, S_JUMP, 0, 0));
    tbl.push_back(mk(6'b001000, 6'b000000, 0, 0, 4, S_I_WB, 0, 0));
    tbl.push_back(mk(6'b001100, 6'b000000, 0, 0, 4, S_I_WB, 0, 0));
    tbl.push_back(mk(6'b001101, 6'b000000, 0, 0, 4, S_I_WB, 0, 0));
    tbl.push_back(mk(6'b101011, 6'b000000, 0, 0, 4, S_MEM_WRITE, 0, 0));
    tbl.push_back(mk(6'b111111, 6'b000000, 0, 0, 2, S_DECODE, 0, 1));
    tbl.push_back(mk(6'b100011, 6'b000000, 2, 3, 10, S_MEM_WB, 0, 0));
    tbl.push_back(mk(6'b101011, 6'b000000, 0, 300, 304, S_MEM_WRITE, 1, 0));
    tbl.push_back(mk(6'b100011, 6'b000000, 260, 0, 265, S_MEM_WB, 1, 0));

    // Reset state, then release: one RESET cycle before the first FETCH
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset outputs", 32'(obs_s), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("first cycle after reset", 32'(obs_s), 32'd0);
    @(posedge clk); #1;

    foreach (tbl[i]) begin
      run_instr(tbl[i].op, tbl[i].fn, tbl[i].fw, tbl[i].mw, 1'b0, ncyc, last, n_tmo, n_ill);
      check($sformatf("cpi[%0d]", i), ncyc, tbl[i].cyc);
      check($sformatf("last state[%0d]", i), 32'(last), 32'(tbl[i].last));
      check($sformatf("timeouts[%0d]", i), n_tmo, tbl[i].tmo);
      check($sformatf("illegal[%0d]", i), n_ill, tbl[i].ill);
    end

    // Reset dropped in the middle of a lw memory read
    opcode = 6'b100011; funct = 6'b000000; mem_ready = 1'b1;
    @(negedge clk);
    check("abort fetch", 32'(state), 32'(S_FETCH));
    @(posedge clk); #1;
    @(negedge clk);
    check("abort decode", 32'(state), 32'(S_DECODE));
    @(posedge clk); #1;
    @(negedge clk);
    check("abort memaddr", 32'(state), 32'(S_MEM_ADDR));
    @(posedge clk); #1;
    mem_ready = 1'b0;
    @(negedge clk);
    check("abort memread", 32'(obs_s), 32'(exp_word(S_MEM_READ, 6'b100011, 1'b0, 1)));
    #2;
    rst_n = 1'b0;
    #1;
    check("async reset outputs", 32'(obs_s), 32'd0);
    mem_ready = 1'b1;
    @(posedge clk); #1;
    check("held in reset", 32'(obs_s), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset cycle after abort", 32'(obs_s), 32'd0);
    @(posedge clk); #1;

    // Random instruction stream
    for (int n = 0; n < 150; n++) begin
      case ($urandom_range(0, 8))
        0: op = 6'b000000;
        1: op = 6'b100011;
        2: op = 6'b101011;
        3: op = 6'b000100;
        4: op = 6'b000010;
        5: op = 6'b001000;
        6: op = 6'b001100;
        7: op = 6'b001101;
        default: begin
          op = 6'($urandom_range(0, 63));
          for (int t = 0; t < 64 && legal(op); t++) op = op + 6'd1;
        end
      endcase
      fn = ($urandom_range(0, 3) == 0) ? 6'b001000 : 6'($urandom_range(0, 63));
      fw = $urandom_range(0, 3);
      mw = $urandom_range(0, 3);
      if (op == 6'b100011) base = 5 + mw;
      else if (op == 6'b101011) base = 4 + mw;
      else if (op == 6'b000000) base = (fn == 6'b001000) ? 3 : 4;
      else if (op inside {6'b001000, 6'b001100, 6'b001101}) base = 4;
      else if (op inside {6'b000100, 6'b000010}) base = 3;
      else base = 2;
      run_instr(op, fn, fw, mw, 1'b1, ncyc, last, n_tmo, n_ill);
      check($sformatf("rand cpi op=%b", op), ncyc, base + fw);
      check($sformatf("rand illegal op=%b", op), n_ill, legal(op) ? 0 : 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main control FSM for the multicycle MIPS datapath. Decodes the opcode latched in the instruction register, sequences fetch/decode/execute/memory/write-back, drives every datapath mux and write enable, and produces the 3-bit `alu_op` consumed by `ALU_control`. It is the only block that talks to the unified instruction/data memory, through a ready-based handshake.

## Interface
- `WAIT_LIMIT`, 255: maximum cycles spent waiting on `mem_ready` in one memory state before `mem_timeout` fires.
- `clk` input 1: system clock, rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `opcode` input 6: instruction[31:26] from the instruction register.
- `funct` input 6: instruction[5:0]; used only to detect `jr`.
- `zero` input 1: ALU zero flag.
- `mem_ready` input 1: memory has completed the current read/write this cycle.
- `pc_write`, `pc_write_cond`, `ir_write`, `reg_write` output 1: write enables.
- `mem_read`, `mem_write` output 1: memory request; held until `mem_ready`.
- `i_or_d` output 1: 0 = PC addresses memory, 1 = ALUOut.
- `mem_to_reg` output 1: 0 = ALUOut, 1 = MDR.
- `reg_dst` output 1: 0 = rt, 1 = rd.
- `ext_sel` output 1: 0 = sign-extend immediate, 1 = zero-extend.
- `alu_src_a` output 1: 0 = PC, 1 = register A.
- `alu_src_b` output 2: 00 = B, 01 = constant 4, 10 = extended imm, 11 = sign-ext imm<<2.
- `alu_op` output 3: 000 add, 010 R-type (use funct), 011 sub, 100 and, 101 or.
- `pc_source` output 2: 00 = ALU result, 01 = ALUOut, 10 = jump target, 11 = register A.
- `illegal_op` output 1: one-cycle pulse on an unsupported opcode.
- `mem_timeout` output 1: one-cycle pulse when a wait exceeds `WAIT_LIMIT`.
- `state` output 4: current state code, for debug.

## Operation
- Opcodes: R=000000, lw=100011, sw=101011, beq=000100, j=000010, addi=001000, andi=001100, ori=001101. `jr` is R with funct=001000.
- States and transitions:
  - RESET → FETCH.
  - FETCH: stays while `mem_ready`=0, else → DECODE.
  - DECODE → one of:
    - MEM_ADDR (lw/sw)
    - R_EXEC (R, not jr)
    - JR
    - I_EXEC (addi/andi/ori)
    - BRANCH (beq)
    - JUMP (j)
    - FETCH (illegal)
  - MEM_ADDR → MEM_READ (lw) or MEM_WRITE (sw).
  - MEM_READ: waits on `mem_ready`, then → MEM_WB.
  - MEM_WRITE: waits on `mem_ready`, then → FETCH.
  - R_EXEC → R_WB; I_EXEC → I_WB.
  - MEM_WB, R_WB, I_WB, BRANCH, JUMP, JR → FETCH.
- Outputs are Moore, except in FETCH, where `ir_write` and `pc_write` equal `mem_ready`.
- Per-state asserted signals (all others 0):
  - FETCH: `mem_read`, `alu_src_b`=01, `alu_op`=000, `pc_source`=00.
  - DECODE: `alu_src_b`=11, `alu_op`=000.
  - MEM_ADDR: `alu_src_a`, `alu_src_b`=10, `alu_op`=000.
  - MEM_READ: `mem_read`, `i_or_d`.
  - MEM_WRITE: `mem_write`, `i_or_d`.
  - MEM_WB: `reg_write`, `mem_to_reg`.
  - R_EXEC: `alu_src_a`, `alu_op`=010.
  - R_WB: `reg_write`, `reg_dst`.
  - I_EXEC: `alu_src_a`, `alu_src_b`=10; `alu_op`=000/100/101 for addi/andi/ori; `ext_sel`=1 for andi/ori.
  - I_WB: `reg_write`, `reg_dst`=0. The `alu_op`/`ext_sel` of I_EXEC are held so ALUOut stays valid.
  - BRANCH: `alu_src_a`, `alu_op`=011, `pc_write_cond`, `pc_source`=01.
  - JUMP: `pc_write`, `pc_source`=10.
  - JR: `pc_write`, `pc_source`=11.
- Opcode and funct are sampled in DECODE and I_EXEC/I_WB only. The IR is stable after FETCH, so no extra latch is required.
- Illegal opcode: `illegal_op`=1 for the DECODE cycle; no architectural write occurs.
- Wait counter:
  - 8 bits; cleared on entry to FETCH/MEM_READ/MEM_WRITE and whenever `mem_ready`=1.
  - Increments per stalled cycle.
  - On reaching `WAIT_LIMIT`: `mem_timeout` pulses once, the counter saturates, and the FSM keeps waiting. No abort.

## Timing
- Reset values: state=RESET (`state`=0000), all outputs 0, wait counter 0.
- Reset assertion mid-instruction aborts immediately. Outputs go to 0 asynchronously and no partial write completes after reset asserts.
- First FETCH occurs in the second cycle after `rst_n` rises.
- Cycles per instruction with zero-wait memory:
  - 3: beq, j, jr.
  - 4: R-type, sw, addi/andi/ori.
  - 5: lw.
- Each memory stall cycle adds 1.
- `mem_ready` outside FETCH/MEM_READ/MEM_WRITE is ignored.
- `mem_read`/`mem_write` never assert together.
- `mem_read`/`mem_write` stay high continuously from state entry through the `mem_ready` cycle.
- beq: PC updates at the end of BRANCH only if `zero`=1 in that cycle.

## Structure
- Shared package `mips_ctrl_pkg` holds:
  - opcode and `jr` funct constants;
  - ALUOp codes (shared with `ALU_control`);
  - `pc_source` and `alu_src_b` codes;
  - state encoding.
- One sub-module, `multicycle_ctrl_decode`: combinational state/opcode → control-word mapping.
- The FSM, wait counter and pulse generation stay in `multicycle_control`.

## Test plan
- Reset release, `mem_ready` tied 1, lw (100011) → states RESET, FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB; `reg_write`=`mem_to_reg`=1 in cycle 5 of the instruction.
- R add, then jr (funct 001000) → add: `alu_op`=010 and `reg_dst`=1 in R_WB; jr: `pc_write`=1 and `pc_source`=11 in its third cycle.
- beq with `zero`=0, then `zero`=1 → `pc_write_cond`=1 and `alu_op`=011 both times; FSM returns to FETCH after 3 cycles.
- ori (001101) → `alu_op`=101 and `ext_sel`=1 through I_EXEC and I_WB; `reg_dst`=0.
- sw with `mem_ready` low for 300 cycles (`WAIT_LIMIT`=255) → `mem_write` held throughout; one `mem_timeout` pulse at stall 255; FETCH entered after ready.
- Opcode 111111 → `illegal_op` pulses once, no write enable asserted, back to FETCH. Separately, `rst_n` dropped during MEM_READ → outputs 0 at once, state=0000.
